// File: rtl/alu_op_driver.sv
// Request/response driver for an external combinational add/sub ALU.
// Operands and the select are registered toward the ALU. After SETTLE cycles the
// ALU result is captured and compared with an internally computed expectation.
// The captured result is then held until the consumer accepts it.
module alu_op_driver #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned SETTLE = 1   // legal range 1..15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_c,
   input  logic [WIDTH-1:0] alu_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic [7:0]       op_count
);

   typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

   localparam logic [3:0] SettleLoad = 4'(SETTLE);

   state_e           state_q;
   logic [3:0]       settle_cnt_q;
   logic [WIDTH-1:0] expected_q;
   logic [WIDTH-1:0] expected_d;

   // Reference result for the incoming request; carry/borrow fall off the top.
   always_comb begin
      expected_d = req_op ? (req_a - req_b) : (req_a + req_b);
   end

   // Handshake flags are decoded from state only, so there is no input-to-output path.
   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);

   // Main FSM with all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         settle_cnt_q <= 4'd0;
         expected_q   <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_c        <= 1'b0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
         op_count     <= 8'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req_valid) begin
                  alu_a        <= req_a;
                  alu_b        <= req_b;
                  alu_c        <= req_op;
                  expected_q   <= expected_d;
                  settle_cnt_q <= SettleLoad;
                  state_q      <= StSettle;
               end
            end
            StSettle: begin
               // A count of one means this edge ends the last settle cycle.
               if (settle_cnt_q <= 4'd1) begin
                  rsp_data     <= alu_out;
                  rsp_err      <= (alu_out != expected_q);
                  settle_cnt_q <= 4'd0;
                  state_q      <= StResp;
               end else begin
                  settle_cnt_q <= settle_cnt_q - 4'd1;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  op_count <= op_count + 8'd1;
                  state_q  <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_driver.sv
// Self-checking bench for alu_op_driver: a directed vector table, multi-cycle corner
// sequences, and a randomized back-to-back run scored against an arithmetic model.
module tb_alu_op_driver;

   localparam int W  = 4;
   localparam int S  = 1;
   localparam int S3 = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic [W-1:0] req_a = '0;
   logic [W-1:0] req_b = '0;
   logic         req_op = 1'b0;
   logic         rsp_ready = 1'b1;
   logic         fault = 1'b0;

   logic         req_ready, alu_c, rsp_valid, rsp_err;
   logic [W-1:0] alu_a, alu_b, alu_out, rsp_data;
   logic [7:0]   op_count;

   logic         req_ready3, alu_c3, rsp_valid3, rsp_err3;
   logic [W-1:0] alu_a3, alu_b3, alu_out3, rsp_data3;
   logic [7:0]   op_count3;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int exp_count = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External ALU models; "fault" forces the main one to stuck-at-zero.
   always_comb begin
      alu_out = fault ? '0 : (alu_c ? alu_a - alu_b : alu_a + alu_b);
   end
   always_comb begin
      alu_out3 = alu_c3 ? alu_a3 - alu_b3 : alu_a3 + alu_b3;
   end

   alu_op_driver #(.WIDTH(W), .SETTLE(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_c(alu_c), .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .op_count(op_count)
   );

   alu_op_driver #(.WIDTH(W), .SETTLE(S3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready3),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .alu_a(alu_a3), .alu_b(alu_b3),
      .alu_c(alu_c3), .alu_out(alu_out3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data3), .rsp_err(rsp_err3), .op_count(op_count3)
   );

   typedef struct {
      int a;
      int b;
      int op;
      int flt;
      int exp_data;
      int exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Arithmetic reference: the result is taken mod 2^W.
   function automatic int ref_result(input int a, input int b, input int op);
      int r;
      r = (op != 0) ? a - b : a + b;
      return ((r % (1 << W)) + (1 << W)) % (1 << W);
   endfunction

   task automatic wait_ready();
      int k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("ready_timeout", 32'(req_ready), 1);
   endtask

   // Issue one request; lat counts negedges from accept until rsp_valid is seen.
   task automatic do_op(input int a, input int b, input int op,
                        output logic [W-1:0] data, output logic err, output int lat);
      @(negedge clk);
      req_a = W'(a);
      req_b = W'(b);
      req_op = op[0];
      req_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      data = '0;
      err = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) begin
            data = rsp_data;
            err = rsp_err;
            break;
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_count = 0;
   endtask

   vec_t         vecs[8];
   logic [W-1:0] d;
   logic         e;
   int           lat;
   int           seen;
   int           acc, prev_acc;
   int           ra, rb, rop, rf;

   initial begin
      vecs[0] = '{3, 4, 0, 0, 7, 0};
      vecs[1] = '{2, 5, 1, 0, 13, 0};
      vecs[2] = '{15, 1, 0, 0, 0, 0};
      vecs[3] = '{6, 1, 0, 1, 0, 1};
      vecs[4] = '{15, 15, 0, 0, 14, 0};
      vecs[5] = '{0, 1, 1, 0, 15, 0};
      vecs[6] = '{9, 9, 1, 0, 0, 0};
      vecs[7] = '{10, 3, 1, 0, 7, 0};

      // Reset state, applied without any clock edge yet.
      #1;
      check("rst_req_ready", 32'(req_ready), 1);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_alu_a", 32'(alu_a), 0);
      check("rst_alu_c", 32'(alu_c), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      check("rst_op_count", 32'(op_count), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // SETTLE=3 instance: rsp_valid four cycles after accept.
      @(negedge clk);
      req_a = 4'd6; req_b = 4'd2; req_op = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (rsp_valid3) break;
      end
      check("settle3_latency", 32'(lat), S3 + 1);
      check("settle3_data", 32'(rsp_data3), 8);
      check("settle3_err", 32'(rsp_err3), 0);
      pulse_reset();

      // Directed vectors, rsp_ready held high.
      rsp_ready = 1'b1;
      foreach (vecs[i]) begin
         fault = vecs[i].flt[0];
         do_op(vecs[i].a, vecs[i].b, vecs[i].op, d, e, lat);
         check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d_latency", i), 32'(lat), S + 1);
         check($sformatf("vec%0d_alu_c", i), 32'(alu_c), 32'(vecs[i].op));
         check($sformatf("vec%0d_alu_a", i), 32'(alu_a), 32'(vecs[i].a));
         exp_count = (exp_count + 1) % 256;
         @(negedge clk);
         check($sformatf("vec%0d_op_count", i), 32'(op_count), 32'(exp_count));
         check($sformatf("vec%0d_idle", i), 32'(req_ready), 1);
         fault = 1'b0;
      end

      // Backpressure with a new request held through RESP.
      rsp_ready = 1'b0;
      @(negedge clk);
      req_a = 4'd3; req_b = 4'd4; req_op = 1'b0; req_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1 req_a = 4'd5; req_b = 4'd2; req_op = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      check("bp_first_data", 32'(rsp_data), 7);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_rsp_valid", 32'(rsp_valid), 1);
         check("bp_rsp_data", 32'(rsp_data), 7);
         check("bp_alu_ab", {alu_a, alu_b}, {4'd3, 4'd4});
         check("bp_alu_c", 32'(alu_c), 0);
         check("bp_req_ready", 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      exp_count = (exp_count + 1) % 256;
      @(negedge clk);
      check("bp_release_valid", 32'(rsp_valid), 0);
      check("bp_release_ready", 32'(req_ready), 1);
      check("bp_release_count", 32'(op_count), 32'(exp_count));
      @(negedge clk);
      check("held_req_alu", {alu_c, alu_a, alu_b}, {1'b1, 4'd5, 4'd2});
      req_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      check("held_req_data", 32'(rsp_data), 3);
      exp_count = (exp_count + 1) % 256;
      @(negedge clk);
      check("held_req_count", 32'(op_count), 32'(exp_count));

      // Reset during SETTLE discards the operation.
      @(negedge clk);
      req_a = 4'd7; req_b = 4'd7; req_op = 1'b0; req_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1 req_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("midrst_req_ready", 32'(req_ready), 1);
      check("midrst_rsp_valid", 32'(rsp_valid), 0);
      check("midrst_alu", {alu_c, alu_a, alu_b}, 0);
      check("midrst_rsp_data", 32'(rsp_data), 0);
      check("midrst_op_count", 32'(op_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_count = 0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      check("midrst_no_rsp", 32'(seen), 0);
      check("midrst_count_after", 32'(op_count), 0);
      do_op(6, 3, 1, d, e, lat);
      check("post_rst_data", 32'(d), 3);
      check("post_rst_latency", 32'(lat), S + 1);
      exp_count = 1;
      @(negedge clk);
      check("post_rst_count", 32'(op_count), 1);

      // 256 randomized back-to-back operations: op_count wraps, fixed throughput.
      pulse_reset();
      rsp_ready = 1'b1;
      prev_acc = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         wait_ready();
         check("rand_op_count", 32'(op_count), 32'(exp_count));
         ra = int'($urandom_range(0, 15));
         rb = int'($urandom_range(0, 15));
         rop = int'($urandom_range(0, 1));
         rf = ($urandom_range(0, 7) == 0) ? 1 : 0;
         req_a = W'(ra); req_b = W'(rb); req_op = rop[0]; req_valid = 1'b1;
         fault = rf[0];
         acc = cyc;
         if (i > 0) check("rand_interval", 32'(acc - prev_acc), S + 2);
         prev_acc = acc;
         @(posedge clk);
         seen = 0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
               seen = 1;
               break;
            end
         end
         check("rand_rsp_seen", 32'(seen), 1);
         check("rand_data", 32'(rsp_data), (rf != 0) ? 0 : ref_result(ra, rb, rop));
         check("rand_err", 32'(rsp_err),
               32'((rf != 0) && (ref_result(ra, rb, rop) != 0)));
         exp_count = (exp_count + 1) % 256;
      end
      req_valid = 1'b0;
      fault = 1'b0;
      @(negedge clk);
      check("wrap_op_count", 32'(op_count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
